// File: rtl/pipeline_debug_controller.sv
// Byte-serial debug controller: program load, run/step/halt control and register dump.
// The dump command is built only when the DEBUG_DUMP_EN macro is defined; otherwise 'D' is NAKed.
module pipeline_debug_controller #(
    parameter int SIZE          = 32,
    parameter int IMEM_AW       = 8,
    parameter int NUM_REGISTERS = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_rx_valid,
    input  logic [7:0]         i_rx_data,
    output logic               o_rx_ready,
    output logic               o_tx_valid,
    output logic [7:0]         o_tx_data,
    input  logic               i_tx_ready,
    output logic               o_stall,
    output logic               o_cpu_rst,
    input  logic               i_halt,
    input  logic [SIZE-1:0]    i_pc,
    output logic               o_imem_we,
    output logic [IMEM_AW-1:0] o_imem_addr,
    output logic [SIZE-1:0]    o_imem_data,
    output logic [4:0]         o_dbg_reg_addr,
    input  logic [SIZE-1:0]    i_dbg_reg_data
);
    localparam int CW = ((IMEM_AW > 8) ? IMEM_AW : 8) + 1;
    localparam logic [CW-1:0] DEPTH   = CW'(2 ** IMEM_AW);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [7:0] CMD_L = 8'h4C;
    localparam logic [7:0] CMD_R = 8'h52;
    localparam logic [7:0] CMD_S = 8'h53;
    localparam logic [7:0] CMD_D = 8'h44;
    localparam logic [7:0] RSP_ACK   = 8'h06;
    localparam logic [7:0] RSP_NAK   = 8'h15;
    localparam logic [7:0] RSP_HALT  = 8'h48;
    localparam logic [7:0] RSP_PAUSE = 8'h50;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        LOAD_CNT  = 4'd1,
        LOAD_BYTE = 4'd2,
        LOAD_WR   = 4'd3,
        RUN       = 4'd4,
        STEP      = 4'd5,
        ACK       = 4'd6
`ifdef DEBUG_DUMP_EN
        ,
        DUMP_ADDR = 4'd7,
        DUMP_SEND = 4'd8
`endif
    } state_e;

    state_e             state_q, state_d;
    logic               stall_q, stall_d;
    logic               cpu_rst_q, cpu_rst_d;
    logic               rx_ready_q, rx_ready_d;
    logic               tx_valid_q, tx_valid_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               imem_we_q, imem_we_d;
    logic [IMEM_AW-1:0] imem_addr_q, imem_addr_d;
    logic [SIZE-1:0]    imem_data_q, imem_data_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [1:0]         byte_idx_q, byte_idx_d;
    logic [31:0]        cycle_q, cycle_d;
    logic               rx_fire_s, tx_fire_s;

    assign rx_fire_s = i_rx_valid && rx_ready_q;
    assign tx_fire_s = tx_valid_q && i_tx_ready;

`ifdef DEBUG_DUMP_EN
    localparam int WIW = $clog2(NUM_REGISTERS + 2);
    localparam logic [WIW-1:0] PC_IDX   = WIW'(NUM_REGISTERS);
    localparam logic [WIW-1:0] LAST_IDX = WIW'(NUM_REGISTERS + 1);
    logic [WIW-1:0] word_idx_q, word_idx_d, next_idx_s;
    logic [4:0]     dbg_addr_q, dbg_addr_d;
    logic [31:0]    word_q, word_d, dump_word_s;

    assign next_idx_s     = word_idx_q + WIW'(1);
    assign o_dbg_reg_addr = dbg_addr_q;

    // Dump word order: register file, then PC, then the cycle counter
    always_comb begin
        if (word_idx_q < PC_IDX) begin
            dump_word_s = i_dbg_reg_data[31:0];
        end else if (word_idx_q == PC_IDX) begin
            dump_word_s = i_pc[31:0];
        end else begin
            dump_word_s = cycle_q;
        end
    end
`else
    logic unused_s;
    assign unused_s       = ^{i_dbg_reg_data, i_pc};
    assign o_dbg_reg_addr = 5'd0;
`endif

    // Next-state and next-output logic for the command FSM
    always_comb begin
        state_d     = state_q;
        stall_d     = stall_q;
        cpu_rst_d   = cpu_rst_q;
        tx_valid_d  = tx_valid_q;
        tx_data_d   = tx_data_q;
        imem_we_d   = 1'b0;
        imem_addr_d = imem_addr_q;
        imem_data_d = imem_data_q;
        cnt_d       = cnt_q;
        byte_idx_d  = byte_idx_q;
        cycle_d     = stall_q ? cycle_q : cycle_q + 32'd1;
`ifdef DEBUG_DUMP_EN
        word_idx_d  = word_idx_q;
        dbg_addr_d  = dbg_addr_q;
        word_d      = word_q;
`endif
        case (state_q)
            IDLE: begin
                if (rx_fire_s) begin
                    case (i_rx_data)
                        CMD_L: begin
                            cpu_rst_d = 1'b1;
                            cycle_d   = 32'd0;
                            state_d   = LOAD_CNT;
                        end
                        CMD_R: begin
                            cpu_rst_d = 1'b0;
                            if (i_halt) begin
                                tx_valid_d = 1'b1;
                                tx_data_d  = RSP_HALT;
                                state_d    = ACK;
                            end else begin
                                stall_d = 1'b0;
                                state_d = RUN;
                            end
                        end
                        CMD_S: begin
                            cpu_rst_d = 1'b0;
                            stall_d   = 1'b0;
                            state_d   = STEP;
                        end
`ifdef DEBUG_DUMP_EN
                        CMD_D: begin
                            word_idx_d = {WIW{1'b0}};
                            dbg_addr_d = 5'd0;
                            state_d    = DUMP_ADDR;
                        end
`endif
                        default: begin
                            tx_valid_d = 1'b1;
                            tx_data_d  = RSP_NAK;
                            state_d    = ACK;
                        end
                    endcase
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD_CNT: begin
                if (rx_fire_s) begin
                    cnt_d       = (i_rx_data == 8'd0) ? DEPTH : CW'(i_rx_data);
                    imem_addr_d = {IMEM_AW{1'b0}};
                    byte_idx_d  = 2'd0;
                    state_d     = LOAD_BYTE;
                end else begin
                    state_d = LOAD_CNT;
                end
            end
            LOAD_BYTE: begin
                if (rx_fire_s) begin
                    imem_data_d = {imem_data_q[SIZE-9:0], i_rx_data};
                    byte_idx_d  = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        imem_we_d = 1'b1;
                        state_d   = LOAD_WR;
                    end else begin
                        state_d = LOAD_BYTE;
                    end
                end else begin
                    state_d = LOAD_BYTE;
                end
            end
            LOAD_WR: begin
                imem_addr_d = imem_addr_q + {{(IMEM_AW-1){1'b0}}, 1'b1};
                cnt_d       = cnt_q - CNT_ONE;
                byte_idx_d  = 2'd0;
                if (cnt_q == CNT_ONE) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = RSP_ACK;
                    state_d    = ACK;
                end else begin
                    state_d = LOAD_BYTE;
                end
            end
            RUN: begin
                // Halt wins over a simultaneous pause byte; the byte is consumed and dropped
                if (i_halt) begin
                    stall_d    = 1'b1;
                    tx_valid_d = 1'b1;
                    tx_data_d  = RSP_HALT;
                    state_d    = ACK;
                end else if (rx_fire_s) begin
                    stall_d    = 1'b1;
                    tx_valid_d = 1'b1;
                    tx_data_d  = RSP_PAUSE;
                    state_d    = ACK;
                end else begin
                    state_d = RUN;
                end
            end
            STEP: begin
                stall_d    = 1'b1;
                tx_valid_d = 1'b1;
                tx_data_d  = RSP_ACK;
                state_d    = ACK;
            end
            ACK: begin
                if (tx_fire_s) begin
                    tx_valid_d = 1'b0;
                    state_d    = IDLE;
                end else begin
                    state_d = ACK;
                end
            end
`ifdef DEBUG_DUMP_EN
            DUMP_ADDR: begin
                word_d     = dump_word_s;
                tx_valid_d = 1'b1;
                tx_data_d  = dump_word_s[31:24];
                byte_idx_d = 2'd0;
                state_d    = DUMP_SEND;
            end
            DUMP_SEND: begin
                if (tx_fire_s) begin
                    if (byte_idx_q == 2'd3) begin
                        tx_valid_d = 1'b0;
                        if (word_idx_q == LAST_IDX) begin
                            dbg_addr_d = 5'd0;
                            state_d    = IDLE;
                        end else begin
                            word_idx_d = next_idx_s;
                            dbg_addr_d = (next_idx_s < PC_IDX) ? 5'(next_idx_s) : 5'd0;
                            state_d    = DUMP_ADDR;
                        end
                    end else begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        word_d     = {word_q[23:0], 8'd0};
                        tx_data_d  = word_q[23:16];
                        state_d    = DUMP_SEND;
                    end
                end else begin
                    state_d = DUMP_SEND;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
        rx_ready_d = ((state_d == IDLE) && !tx_valid_d) || (state_d == LOAD_CNT) ||
                     (state_d == LOAD_BYTE) || (state_d == RUN);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            stall_q     <= 1'b1;
            cpu_rst_q   <= 1'b1;
            rx_ready_q  <= 1'b0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= 8'd0;
            imem_we_q   <= 1'b0;
            imem_addr_q <= {IMEM_AW{1'b0}};
            imem_data_q <= {SIZE{1'b0}};
            cnt_q       <= {CW{1'b0}};
            byte_idx_q  <= 2'd0;
            cycle_q     <= 32'd0;
`ifdef DEBUG_DUMP_EN
            word_idx_q  <= {WIW{1'b0}};
            dbg_addr_q  <= 5'd0;
            word_q      <= 32'd0;
`endif
        end else begin
            state_q     <= state_d;
            stall_q     <= stall_d;
            cpu_rst_q   <= cpu_rst_d;
            rx_ready_q  <= rx_ready_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
            imem_we_q   <= imem_we_d;
            imem_addr_q <= imem_addr_d;
            imem_data_q <= imem_data_d;
            cnt_q       <= cnt_d;
            byte_idx_q  <= byte_idx_d;
            cycle_q     <= cycle_d;
`ifdef DEBUG_DUMP_EN
            word_idx_q  <= word_idx_d;
            dbg_addr_q  <= dbg_addr_d;
            word_q      <= word_d;
`endif
        end
    end

    assign o_rx_ready  = rx_ready_q;
    assign o_tx_valid  = tx_valid_q;
    assign o_tx_data   = tx_data_q;
    assign o_stall     = stall_q;
    assign o_cpu_rst   = cpu_rst_q;
    assign o_imem_we   = imem_we_q;
    assign o_imem_addr = imem_addr_q;
    assign o_imem_data = imem_data_q;
endmodule

// File: tb/tb_pipeline_debug_controller.sv
// Randomized directed bench for pipeline_debug_controller against a transaction-level model.
// Dump checks are compiled when DEBUG_DUMP_EN is defined; otherwise 'D' must be NAKed.
module tb_pipeline_debug_controller;
    localparam int NR = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_rx_valid, i_halt;
    logic [7:0]  i_rx_data;
    logic        o_rx_ready, o_tx_valid, o_stall, o_cpu_rst, o_imem_we;
    logic [7:0]  o_tx_data, o_imem_addr;
    logic        i_tx_ready = 1'b1;
    logic [31:0] i_pc, o_imem_data, i_dbg_reg_data;
    logic [4:0]  o_dbg_reg_addr;

    logic [31:0] regfile [NR];
    logic [31:0] pc_val;

    assign i_dbg_reg_data = regfile[o_dbg_reg_addr];
    assign i_pc = pc_val;

    pipeline_debug_controller dut (
        .clk(clk), .rst(rst),
        .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data), .o_rx_ready(o_rx_ready),
        .o_tx_valid(o_tx_valid), .o_tx_data(o_tx_data), .i_tx_ready(i_tx_ready),
        .o_stall(o_stall), .o_cpu_rst(o_cpu_rst), .i_halt(i_halt), .i_pc(i_pc),
        .o_imem_we(o_imem_we), .o_imem_addr(o_imem_addr), .o_imem_data(o_imem_data),
        .o_dbg_reg_addr(o_dbg_reg_addr), .i_dbg_reg_data(i_dbg_reg_data)
    );

    always #5 clk = ~clk;

    // Response-side backpressure: 0 always ready, 1 toggling, 2 random
    int tx_mode = 0;
    always @(posedge clk) begin
        #1;
        case (tx_mode)
            0: i_tx_ready = 1'b1;
            1: i_tx_ready = ~i_tx_ready;
            default: i_tx_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Observation: completed TX bytes, write pulses, unstalled cycles, protocol violations
    logic [7:0]  got_tx[$];
    logic [7:0]  got_we_addr[$];
    logic [31:0] got_we_data[$];
    int          stall0_cnt = 0;
    int          stab_err = 0;
    logic        prev_wait = 1'b0;
    logic [7:0]  prev_data = 8'd0;
    always @(negedge clk) begin
        if (o_tx_valid && i_tx_ready) got_tx.push_back(o_tx_data);
        if (prev_wait && (!o_tx_valid || o_tx_data !== prev_data)) stab_err++;
        prev_wait = rst && o_tx_valid && !i_tx_ready;
        prev_data = o_tx_data;
        if (o_imem_we) begin
            got_we_addr.push_back(o_imem_addr);
            got_we_data.push_back(o_imem_data);
            if (!o_cpu_rst) stab_err++;
        end
        if (!o_stall) stall0_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Reference model state
    int          n_vec = 0;
    int          n_err = 0;
    int          tx_rd = 0;
    int          we_rd = 0;
    logic [31:0] cyc = 32'd0;
    logic [7:0]  exp_tx[$];
    logic [7:0]  exp_we_addr[$];
    logic [31:0] exp_we_data[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int  t = 0;
        bit  done = 1'b0;
        i_rx_valid = 1'b1;
        i_rx_data  = b;
        while (!done && t < 300) begin
            @(negedge clk);
            if (o_rx_ready) done = 1'b1;
            t++;
        end
        @(posedge clk); #1;
        i_rx_valid = 1'b0;
        if (!done) chk("rx_accept_timeout", 32'(t), 32'd0);
    endtask

    task automatic expect_tx(input string tag);
        int t = 0;
        int n = exp_tx.size();
        while ((got_tx.size() < tx_rd + n) && (t < 6000)) begin
            @(posedge clk); #1;
            t++;
        end
        if (got_tx.size() < tx_rd + n) chk({tag, "_count"}, 32'(got_tx.size() - tx_rd), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (tx_rd < got_tx.size()) begin
                chk(tag, 32'(got_tx[tx_rd]), 32'(exp_tx[i]));
                tx_rd++;
            end
        end
        exp_tx.delete();
        repeat (3) begin @(posedge clk); #1; end
        chk({tag, "_extra"}, 32'(got_tx.size()), 32'(tx_rd));
        tx_rd = got_tx.size();
    endtask

    task automatic expect_we(input string tag);
        int n = exp_we_addr.size();
        chk({tag, "_count"}, 32'(got_we_addr.size() - we_rd), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (we_rd + i < got_we_addr.size()) begin
                chk({tag, "_addr"}, 32'(got_we_addr[we_rd + i]), 32'(exp_we_addr[i]));
                chk({tag, "_data"}, got_we_data[we_rd + i], exp_we_data[i]);
            end
        end
        exp_we_addr.delete();
        exp_we_data.delete();
        we_rd = got_we_addr.size();
    endtask

    task automatic do_load(input logic [31:0] words[$]);
        int n = words.size();
        send_byte(8'h4C);
        send_byte(8'(n));
        for (int i = 0; i < n; i++) begin
            for (int k = 3; k >= 0; k--) send_byte(8'(words[i] >> (8 * k)));
            exp_we_addr.push_back(8'(i));
            exp_we_data.push_back(words[i]);
        end
        cyc = 32'd0;
        exp_tx.push_back(8'h06);
        expect_tx("load_ack");
        expect_we("load_we");
        chk("load_cpu_rst", 32'(o_cpu_rst), 32'd1);
    endtask

    task automatic do_step();
        int s0 = stall0_cnt;
        send_byte(8'h53);
        exp_tx.push_back(8'h06);
        expect_tx("step_ack");
        chk("step_stall0", 32'(stall0_cnt - s0), 32'd1);
        chk("step_cpu_rst", 32'(o_cpu_rst), 32'd0);
        cyc = cyc + 32'd1;
    endtask

    task automatic run_halt(input int n);
        int s0 = stall0_cnt;
        int c = 0;
        int t = 0;
        if (n == 0) i_halt = 1'b1;
        send_byte(8'h52);
        if (n > 0) begin
            while (c < n && t < 3000) begin
                @(negedge clk);
                if (!o_stall) c++;
                t++;
            end
            i_halt = 1'b1;
        end
        exp_tx.push_back(8'h48);
        expect_tx("run_halt_rsp");
        i_halt = 1'b0;
        chk("run_halt_stall0", 32'(stall0_cnt - s0), 32'(n));
        chk("run_cpu_rst", 32'(o_cpu_rst), 32'd0);
        cyc = cyc + 32'(n);
    endtask

    task automatic run_pause(input int k, input bit with_halt);
        int s0 = stall0_cnt;
        send_byte(8'h52);
        repeat (k) begin @(posedge clk); #1; end
        if (with_halt) i_halt = 1'b1;
        send_byte(with_halt ? 8'h00 : 8'($urandom));
        exp_tx.push_back(with_halt ? 8'h48 : 8'h50);
        expect_tx(with_halt ? "halt_prio_rsp" : "pause_rsp");
        i_halt = 1'b0;
        chk("pause_stall0", 32'(stall0_cnt - s0), 32'(k + 1));
        cyc = cyc + 32'(k + 1);
    endtask

    task automatic nak_cmd(input logic [7:0] b);
        send_byte(b);
        exp_tx.push_back(8'h15);
        expect_tx("nak");
    endtask

    task automatic do_dump();
        int s0;
        logic [31:0] v;
        for (int i = 0; i < NR; i++) regfile[i] = $urandom;
        regfile[1] = 32'hDEADBEEF;
        pc_val = $urandom;
        tx_mode = 1;
        s0 = stall0_cnt;
        send_byte(8'h44);
        for (int w = 0; w < NR + 2; w++) begin
            v = (w < NR) ? regfile[w] : ((w == NR) ? pc_val : cyc);
            for (int k = 3; k >= 0; k--) exp_tx.push_back(8'(v >> (8 * k)));
        end
        expect_tx("dump_byte");
        chk("dump_stall0", 32'(stall0_cnt - s0), 32'd0);
        tx_mode = 0;
    endtask

    initial begin
        logic [31:0] wq[$];
        logic [7:0]  b;
        i_rx_valid = 1'b0;
        i_rx_data  = 8'd0;
        i_halt     = 1'b0;
        pc_val     = 32'h0000_0100;
        for (int i = 0; i < NR; i++) regfile[i] = 32'(i);

        repeat (3) @(negedge clk);
        chk("rst_stall", 32'(o_stall), 32'd1);
        chk("rst_cpu_rst", 32'(o_cpu_rst), 32'd1);
        chk("rst_rx_ready", 32'(o_rx_ready), 32'd0);
        chk("rst_tx_valid", 32'(o_tx_valid), 32'd0);
        chk("rst_imem_we", 32'(o_imem_we), 32'd0);
        chk("rst_tx_data", 32'(o_tx_data), 32'd0);
        chk("rst_imem_addr", 32'(o_imem_addr), 32'd0);
        chk("rst_imem_data", o_imem_data, 32'd0);
        chk("rst_dbg_addr", 32'(o_dbg_reg_addr), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rx_ready_after_rst", 32'(o_rx_ready), 32'd1);

        wq = {32'h20010005, 32'h00000000};
        do_load(wq);
        run_halt(10);
`ifdef DEBUG_DUMP_EN
        do_dump();
`else
        nak_cmd(8'h44);
`endif

        tx_mode = 2;
        wq.delete();
        repeat ($urandom_range(1, 6)) wq.push_back($urandom);
        do_load(wq);
        repeat (3) do_step();
`ifdef DEBUG_DUMP_EN
        do_dump();
        tx_mode = 2;
`endif

        for (int it = 0; it < 4; it++) begin
            run_halt($urandom_range(1, 20));
            run_pause($urandom_range(0, 8), 1'b0);
            do b = 8'($urandom); while (b == 8'h4C || b == 8'h52 || b == 8'h53 || b == 8'h44);
            nak_cmd(b);
            do_step();
        end
        run_pause($urandom_range(0, 5), 1'b1);
        run_halt(0);
`ifdef DEBUG_DUMP_EN
        do_dump();
`endif

        tx_mode = 0;
        wq.delete();
        for (int i = 0; i < 256; i++) wq.push_back($urandom);
        do_load(wq);

        send_byte(8'h4C);
        send_byte(8'h01);
        send_byte(8'($urandom));
        send_byte(8'($urandom));
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("midload_rst_cpu_rst", 32'(o_cpu_rst), 32'd1);
        chk("midload_rst_stall", 32'(o_stall), 32'd1);
        chk("midload_rst_tx_valid", 32'(o_tx_valid), 32'd0);
        chk("midload_rst_rx_ready", 32'(o_rx_ready), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midload_rx_ready", 32'(o_rx_ready), 32'd1);
        chk("midload_no_we", 32'(got_we_addr.size()), 32'(we_rd));
        chk("midload_no_tx", 32'(got_tx.size()), 32'(tx_rd));
        cyc = 32'd0;
        nak_cmd(8'h5A);
        wq.delete();
        wq.push_back($urandom);
        do_load(wq);
        do_step();
`ifdef DEBUG_DUMP_EN
        do_dump();
`endif

        chk("protocol_violations", 32'(stab_err), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
